align_shift_arbiter: RTL

Round-robin arbiter that shares one 24-bit mantissa right shifter among several Vector ALU requesters, such as the FP add/sub alignment lanes. It accepts shift requests over valid/ready handshakes and drives the shared shifter combinationally from the granted request. It also computes the sticky bit (OR of all bits shifted out) and returns the result with the requester ID through a single registered, back-pressurable output stage.

---
 rtl/align_shift_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/align_shift_arbiter.sv
// align_shift_arbiter: round-robin share of one 24-bit mantissa right shifter with sticky.
// Rev 1.0
`default_nettype none

module align_shift_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*24-1:0] req_mant,
  input  logic [NUM_REQ*8-1:0]  req_amt,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [23:0]           resp_mant,
  output logic                  resp_sticky,
  output logic [ID_W-1:0]       resp_id,
  output logic [15:0]           stall_cnt
);

  localparam logic [15:0] C_STALL_MAX = 16'hFFFF;

  logic                 resp_valid_q, resp_valid_d;
  logic [23:0]          resp_mant_q, resp_mant_d;
  logic                 resp_sticky_q, resp_sticky_d;
  logic [ID_W-1:0]      resp_id_q, resp_id_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [15:0]          stall_q, stall_d;

  logic                 w_free;
  logic                 w_gnt_vld;
  logic [ID_W-1:0]      w_gnt;
  logic [NUM_REQ-1:0]   w_rot;
  logic [23:0]          w_mant;
  logic [7:0]           w_amt;
  logic [23:0]          w_shifted;
  logic [23:0]          w_mask;
  logic                 w_sticky;
  logic                 w_xfer;

  assign w_free = !resp_valid_q || resp_ready;

  // Rotate the valid vector so that bit 0 is the requester at ptr; lowest set bit wins.
  assign w_rot = NUM_REQ'({req_valid, req_valid} >> ptr_q);

  always_comb begin
    int off;
    int sum;
    w_gnt_vld = 1'b0;
    off       = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_gnt_vld = 1'b1;
        off       = j;
      end
    end
    sum = int'(ptr_q) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    w_gnt = ID_W'(sum);
  end

  always_comb begin
    w_mant = '0;
    w_amt  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt == ID_W'(i)) begin
        w_mant = req_mant[i*24 +: 24];
        w_amt  = req_amt[i*8 +: 8];
      end
    end
  end

  always_comb begin
    if (w_amt >= 8'd24) begin
      w_shifted = '0;
      w_mask    = '1;
    end else begin
      w_shifted = w_mant >> w_amt;
      w_mask    = (24'h1 << w_amt) - 24'h1;
    end
    w_sticky = |(w_mant & w_mask);
  end

  assign req_ready = (w_gnt_vld && w_free && rst_n) ? (NUM_REQ'(1) << w_gnt) : '0;
  assign w_xfer    = |req_ready;

  always_comb begin
    resp_valid_d  = resp_valid_q;
    resp_mant_d   = resp_mant_q;
    resp_sticky_d = resp_sticky_q;
    resp_id_d     = resp_id_q;
    ptr_d         = ptr_q;
    stall_d       = stall_q;
    if (w_xfer) begin
      resp_valid_d  = 1'b1;
      resp_mant_d   = w_shifted;
      resp_sticky_d = w_sticky;
      resp_id_d     = w_gnt;
      ptr_d         = (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + ID_W'(1);
    end else if (resp_ready) begin
      resp_valid_d  = 1'b0;
    end
    if (|req_valid && !w_free && stall_q != C_STALL_MAX) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q  <= 1'b0;
      resp_mant_q   <= '0;
      resp_sticky_q <= 1'b0;
      resp_id_q     <= '0;
      ptr_q         <= '0;
      stall_q       <= '0;
    end else begin
      resp_valid_q  <= resp_valid_d;
      resp_mant_q   <= resp_mant_d;
      resp_sticky_q <= resp_sticky_d;
      resp_id_q     <= resp_id_d;
      ptr_q         <= ptr_d;
      stall_q       <= stall_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_mant   = resp_mant_q;
  assign resp_sticky = resp_sticky_q;
  assign resp_id     = resp_id_q;
  assign stall_cnt   = stall_q;

endmodule

`default_nettype wire
